// File: rtl/usq_pkg.sv
// Shared definitions for the microprogram sequencer: next-state control
// encodings and default geometry.
package usq_pkg;

    localparam int ADDR_W_DEF      = 7;
    localparam int RESET_STATE_DEF = 0;

    typedef enum logic [2:0] {
        NS_DISPATCH = 3'b000,
        NS_INC      = 3'b001,
        NS_CJMP     = 3'b010,
        NS_JMP      = 3'b011,
        NS_CDISP    = 3'b100,
        NS_WAIT     = 3'b101,
        NS_CALL     = 3'b110,
        NS_RET      = 3'b111
    } ns_ctl_e;

endpackage

// File: rtl/microsequencer_if.sv
// Microinstruction/encoder inputs and sequencer outputs. The master is the
// control path that feeds the sequencer; the slave is the sequencer itself.
interface microsequencer_if #(
    parameter int ADDR_W = usq_pkg::ADDR_W_DEF
);
    logic [ADDR_W-1:0] encoder_in;
    logic [ADDR_W-1:0] jump_addr;
    logic [2:0]        ns_ctl;
    logic              cond_in;
    logic              cond_inv;
    logic              mfc;
    logic [ADDR_W-1:0] state;
    logic              waiting;
    logic              stack_err;

    modport master (
        output encoder_in, jump_addr, ns_ctl, cond_in, cond_inv, mfc,
        input  state, waiting, stack_err
    );

    modport slave (
        input  encoder_in, jump_addr, ns_ctl, cond_in, cond_inv, mfc,
        output state, waiting, stack_err
    );
endinterface

// File: rtl/usq_return_stack.sv
// LIFO of return microstates. Push when full and pop when empty are dropped
// here; the parent decides what those mean.
module usq_return_stack #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][ADDR_W-1:0] mem;
    logic [CNT_W-1:0]             cnt;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (i == int'(cnt) - 1) top = mem[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '0;
            cnt <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++)
                if (i == int'(cnt)) mem[i] <= push_data;
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: picks the next microstate from dispatch, increment,
// jump target or return stack each cycle and registers it.
module microsequencer
    import usq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = 2,
    parameter int RESET_STATE = RESET_STATE_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    microsequencer_if.slave    bus
);
    logic [ADDR_W-1:0] state_q, state_d, inc, top;
    logic              c, push, pop, full, empty, err_q, err_set;

    assign c   = bus.cond_in ^ bus.cond_inv;
    assign inc = state_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (ns_ctl_e'(bus.ns_ctl))
            NS_DISPATCH: state_d = bus.encoder_in;
            NS_INC:      state_d = inc;
            NS_CJMP:     state_d = c ? bus.jump_addr : inc;
            NS_JMP:      state_d = bus.jump_addr;
            NS_CDISP:    state_d = c ? bus.jump_addr : bus.encoder_in;
            NS_WAIT:     if (bus.mfc) state_d = inc;
            NS_CALL: begin
                // The jump is taken even when the return address is lost.
                state_d = bus.jump_addr;
                push    = !full;
                err_set = full;
            end
            NS_RET: begin
                if (empty) begin
                    state_d = ADDR_W'(RESET_STATE);
                    err_set = 1'b1;
                end else begin
                    state_d = top;
                    pop     = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ADDR_W'(RESET_STATE);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    usq_return_stack #(.DEPTH(STACK_DEPTH), .ADDR_W(ADDR_W)) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (inc),
        .top       (top),
        .full      (full),
        .empty     (empty)
    );

    // Gated by reset so waiting drops the moment reset is asserted.
    assign bus.waiting   = reset_n && (bus.ns_ctl == NS_WAIT) && !bus.mfc;
    assign bus.state     = state_q;
    assign bus.stack_err = err_q;
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a queue-based model checked every cycle
// plus literal expectations that pin the model.
module tb_microsequencer;
    localparam int AW    = 7;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    microsequencer_if #(.ADDR_W(AW)) bus ();

    microsequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_STATE(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: integer state, queue as the return stack, sticky error flag.
    int m_state = 0;
    int m_stk[$];
    bit m_err = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0;
            m_stk.delete();
            m_err = 0;
        end else begin
            int incv;
            bit cc;
            incv = (m_state + 1) % (1 << AW);
            cc   = bus.cond_in ^ bus.cond_inv;
            case (bus.ns_ctl)
                3'd0: m_state = int'(bus.encoder_in);
                3'd1: m_state = incv;
                3'd2: m_state = cc ? int'(bus.jump_addr) : incv;
                3'd3: m_state = int'(bus.jump_addr);
                3'd4: m_state = cc ? int'(bus.jump_addr) : int'(bus.encoder_in);
                3'd5: if (bus.mfc) m_state = incv;
                3'd6: begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(incv);
                    else m_err = 1;
                    m_state = int'(bus.jump_addr);
                end
                default: begin
                    if (m_stk.size() > 0) m_state = m_stk.pop_back();
                    else begin m_state = 0; m_err = 1; end
                end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit w;
        w = reset_n && (bus.ns_ctl == 3'd5) && !bus.mfc;
        chk("model_state", int'(bus.state), m_state);
        chk("model_waiting", int'(bus.waiting), int'(w));
        chk("model_stack_err", int'(bus.stack_err), int'(m_err));
    end

    // Called at posedge+2; drives the op and returns after it has been loaded.
    task automatic op(input logic [2:0] ctl, input int enc = 0, input int jmp = 0,
                      input bit ci = 0, input bit cv = 0, input bit m = 0);
        bus.ns_ctl     = ctl;
        bus.encoder_in = AW'(enc);
        bus.jump_addr  = AW'(jmp);
        bus.cond_in    = ci;
        bus.cond_inv   = cv;
        bus.mfc        = m;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.ns_ctl = 3'd1; bus.encoder_in = '0; bus.jump_addr = '0;
        bus.cond_in = 0; bus.cond_inv = 0; bus.mfc = 0;
        #1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_err", int'(bus.stack_err), 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #2;
        chk("inc_after_reset", int'(bus.state), 1);

        // Async reset in the middle of a WAIT
        op(3'd0, 45);
        chk("dispatch_45", int'(bus.state), 45);
        op(3'd5, 0, 0, 0, 0, 0);
        bus.ns_ctl = 3'd5; bus.mfc = 0; #1;
        chk("wait_hold_45", int'(bus.state), 45);
        chk("waiting_hi", int'(bus.waiting), 1);
        reset_n = 1'b0; #1;
        chk("async_rst_state", int'(bus.state), 0);
        chk("async_rst_waiting", int'(bus.waiting), 0);
        chk("async_rst_err", int'(bus.stack_err), 0);
        bus.ns_ctl = 3'd1;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #2;
        chk("inc_after_rst2", int'(bus.state), 1);

        // Dispatch, increment, wrap
        op(3'd0, 0); op(3'd0, 43);
        chk("dispatch_43", int'(bus.state), 43);
        op(3'd1);
        chk("inc_44", int'(bus.state), 44);
        op(3'd3, 0, 127); op(3'd1);
        chk("wrap_0", int'(bus.state), 0);
        chk("wrap_no_err", int'(bus.stack_err), 0);
        op(3'd0, 91);
        chk("dispatch_91", int'(bus.state), 91);

        // Conditional ops
        op(3'd3, 0, 5); op(3'd2, 0, 20, 1, 0);
        chk("cjmp_taken", int'(bus.state), 20);
        op(3'd3, 0, 5); op(3'd2, 0, 20, 1, 1);
        chk("cjmp_inv_not_taken", int'(bus.state), 6);
        op(3'd4, 40, 20, 0, 0);
        chk("cdisp_c0", int'(bus.state), 40);
        op(3'd4, 40, 20, 0, 1);
        chk("cdisp_c1", int'(bus.state), 20);

        // Memory wait
        op(3'd3, 0, 30);
        for (int i = 0; i < 3; i++) begin
            op(3'd5, 0, 0, 0, 0, 0);
            chk("wait_hold_30", int'(bus.state), 30);
        end
        bus.mfc = 1; #1;
        chk("waiting_lo_mfc", int'(bus.waiting), 0);
        op(3'd5, 0, 0, 0, 0, 1);
        chk("wait_done_31", int'(bus.state), 31);

        // Nested call/return
        op(3'd3, 0, 10); op(3'd6, 0, 60);
        chk("call_60", int'(bus.state), 60);
        op(3'd6, 0, 70);
        chk("call_70", int'(bus.state), 70);
        op(3'd7);
        chk("ret_61", int'(bus.state), 61);
        op(3'd7);
        chk("ret_11", int'(bus.state), 11);
        chk("callret_no_err", int'(bus.stack_err), 0);

        // Overflow then underflow
        op(3'd3, 0, 10); op(3'd6, 0, 60); op(3'd6, 0, 70); op(3'd6, 0, 80);
        chk("ovf_jump", int'(bus.state), 80);
        chk("ovf_err", int'(bus.stack_err), 1);
        op(3'd7);
        chk("ovf_ret_61", int'(bus.state), 61);
        op(3'd7);
        chk("ovf_ret_11", int'(bus.state), 11);
        op(3'd3, 0, 50); op(3'd7);
        chk("unf_state", int'(bus.state), 0);
        chk("unf_err", int'(bus.stack_err), 1);
        op(3'd1); op(3'd0, 12);
        chk("err_sticky", int'(bus.stack_err), 1);
        reset_n = 1'b0; #1;
        chk("err_cleared", int'(bus.stack_err), 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #2;
        op(3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Control-unit microprogram sequencer. It sits directly downstream of the instruction encoder.
- Each cycle it selects the next microstate from one of four sources, under control of the current microinstruction's next-state field:
  - encoder dispatch value
  - incremented current state
  - jump target
  - return stack
- It registers the selected state. The registered state addresses the microstore (control ROM) that produces the next microinstruction.

Parameters:
- ADDR_W, 7, microstate width; must equal encoder output width.
- STACK_DEPTH, 2, return-stack entries (1..4).
- RESET_STATE, 0, microstate loaded on reset and on pop-underflow.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- encoder_in  in  ADDR_W  dispatch microstate from instruction encoder.
- jump_addr  in  ADDR_W  target field of current microinstruction.
- ns_ctl  in  3  next-state control field of current microinstruction.
- cond_in  in  1  condition tester result (ARM cond field / flags).
- cond_inv  in  1  invert cond_in before use.
- mfc  in  1  memory function complete, from memory interface.
- state  out  ADDR_W  current microstate (registered).
- waiting  out  1  high while held in a WAIT op with mfc low (combinational).
- stack_err  out  1  sticky; set on push-overflow or pop-underflow.

Behaviour:
- Reset (async, reset_n=0):
  - state=RESET_STATE, stack empty (depth count 0), stack_err=0.
  - Takes effect immediately, including mid-WAIT or mid-call.
- Effective condition: c = cond_in XOR cond_inv.
- inc = state+1 modulo 2^ADDR_W; 127 -> 0 wraps silently, no error.
- ns_ctl encodings, next state loaded at the next rising edge:
  - 000 DISPATCH: encoder_in.
  - 001 INC: inc.
  - 010 CJMP: c ? jump_addr : inc.
  - 011 JMP: jump_addr.
  - 100 CDISP: c ? jump_addr : encoder_in. Used in fetch to trap on a failed condition.
  - 101 WAIT:
    - mfc=0: hold state, waiting=1.
    - mfc=1: inc, waiting=0.
    - Latency 1 cycle after mfc rises; no timeout.
  - 110 CALL: push inc, load jump_addr.
    - Stack full: no push, stack_err<=1, jump still taken.
  - 111 RET: pop top, load popped value.
    - Stack empty: load RESET_STATE, stack_err<=1.
- Single-cycle decision: next state depends only on inputs and state sampled at the same edge; no internal pipeline.
- Stack is LIFO. Only CALL/RET modify it; all other ops leave it untouched.
- stack_err clears only on reset.
- waiting=0 for every ns_ctl other than WAIT.
- Undefined/unused inputs: encoder_in values (e.g. 91 for unsupported opcodes) are dispatched unchanged; no decoding here.

Decomposition:
- Shared package `usq_pkg`:
  - ns_ctl encodings as named constants: NS_DISPATCH .. NS_RET.
  - ADDR_W default.
  - RESET_STATE default.
- One natural sub-module: `usq_return_stack`:
  - Ports: clk, reset_n, push, pop, push_data, top, full, empty.
  - Register array plus pointer.
  - Push on full and pop on empty are ignored internally; the error is flagged by the parent.
- Top level holds the state register, incrementer, condition XOR, next-state mux and stack_err flag.

Test Plan:
- Reset mid-operation: drive reset_n=0 during WAIT at state 45 -> state=0, waiting=0, stack_err=0 immediately (asynchronous); after release, INC -> state=1.
- Dispatch: state=0, ns_ctl=000, encoder_in=43 -> state=43 next edge. Then ns_ctl=001 -> 44. From 127, INC -> 0, stack_err stays 0.
- Conditional ops: ns_ctl=010, jump_addr=20, state=5:
  - cond_in=1, cond_inv=0 -> 20.
  - cond_in=1, cond_inv=1 -> 6.
  - ns_ctl=100, c=0, encoder_in=40 -> 40.
  - ns_ctl=100, c=1 -> 20.
- Memory wait: state=30, ns_ctl=101, mfc=0 for 3 cycles -> state holds 30, waiting=1. mfc=1 -> state=31, waiting=0 on the same edge.
- Call/return:
  - state=10: CALL jump_addr=60 -> 60.
  - state=60: CALL jump_addr=70 -> 70.
  - RET -> 61; RET -> 11; stack_err=0.
- Stack errors:
  - Third nested CALL with STACK_DEPTH=2 -> jump taken, stack_err=1, subsequent two RETs still return the first two pushed addresses.
  - RET on empty stack -> state=0, stack_err stays 1 until reset.
